// File: rtl/leaf_pkg.sv
// +--------------------------------------------------------------------------+
// | leaf_pkg : constants shared by the leaf datapath blocks                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package leaf_pkg;

   localparam int LEAF_PAYLOAD_BITS    = 32;
   localparam int LEAF_USER_FIFO_DEPTH = 16;

   // Occupancy counters need one bit more than the pointers to represent "full".
   function automatic int leaf_cnt_bits(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : leaf_pkg

`default_nettype wire

// File: rtl/leaf_lutram_sdp.sv
// +--------------------------------------------------------------------------+
// | leaf_lutram_sdp : simple dual-port LUTRAM, sync write / async read        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module leaf_lutram_sdp
   import leaf_pkg::*;
#(
   parameter int WIDTH     = LEAF_PAYLOAD_BITS,
   parameter int DEPTH     = LEAF_USER_FIFO_DEPTH,
   parameter int ADDR_BITS = $clog2(DEPTH)
)(
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage carries no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : leaf_lutram_sdp

`default_nettype wire

// File: rtl/leaf_user_in_fifo.sv
// +--------------------------------------------------------------------------+
// | leaf_user_in_fifo : FWFT elastic input buffer, leaf_interface -> kernel   |
// | Optional statistics outputs enabled by LEAF_USER_FIFO_STATS_EN.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module leaf_user_in_fifo
   import leaf_pkg::*;
#(
   parameter int PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
   parameter int DEPTH        = LEAF_USER_FIFO_DEPTH,
   parameter int CNT_BITS     = leaf_cnt_bits(DEPTH)
)(
   input  logic                    clk_user,
   input  logic                    reset_n,
   input  logic [PAYLOAD_BITS-1:0] din_interface,
   input  logic                    vld_interface,
   output logic                    ack_user,
   output logic [PAYLOAD_BITS-1:0] dout_user,
   output logic                    empty_n_user,
   input  logic                    read_user,
   output logic [CNT_BITS-1:0]     level
`ifdef LEAF_USER_FIFO_STATS_EN
   ,
   output logic [CNT_BITS-1:0]     max_level,
   output logic                    err_underflow
`endif
);

   localparam int                  PTR_BITS   = $clog2(DEPTH);
   localparam logic [CNT_BITS-1:0] FULL_LEVEL = CNT_BITS'(DEPTH);

   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic [CNT_BITS-1:0] level_next;
   logic                wr_en;
   logic                rd_en;

   assign wr_en = vld_interface & ack_user;
   assign rd_en = read_user & empty_n_user;

   always_comb begin
      level_next = level + CNT_BITS'(wr_en) - CNT_BITS'(rd_en);
   end

   // Flags come from level_next so they are registered alongside level itself;
   // a read at full therefore only re-opens ack on the following cycle.
   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         empty_n_user <= 1'b0;
         ack_user     <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         level        <= level_next;
         empty_n_user <= (level_next != '0);
         ack_user     <= (level_next != FULL_LEVEL);
      end
   end

   leaf_lutram_sdp #(
      .WIDTH     (PAYLOAD_BITS),
      .DEPTH     (DEPTH),
      .ADDR_BITS (PTR_BITS)
   ) u_ram (
      .clk   (clk_user),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (din_interface),
      .raddr (rd_ptr),
      .rdata (dout_user)
   );

`ifdef LEAF_USER_FIFO_STATS_EN
   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         max_level     <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (level_next > max_level) max_level <= level_next;
         if (read_user && !empty_n_user) err_underflow <= 1'b1;
      end
   end
`endif

endmodule : leaf_user_in_fifo

`default_nettype wire

// File: tb/tb_leaf_user_in_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_leaf_user_in_fifo : queue-model checked bench for leaf_user_in_fifo    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_leaf_user_in_fifo;

   localparam int W     = 32;
   localparam int DEPTH = 16;
   localparam int CB    = $clog2(DEPTH) + 1;

   logic          clk_user = 1'b0;
   logic          reset_n  = 1'b0;
   logic [W-1:0]  din_interface = '0;
   logic          vld_interface = 1'b0;
   logic          ack_user;
   logic [W-1:0]  dout_user;
   logic          empty_n_user;
   logic          read_user = 1'b0;
   logic [CB-1:0] level;
`ifdef LEAF_USER_FIFO_STATS_EN
   logic [CB-1:0] max_level;
   logic          err_underflow;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_user = ~clk_user;

   leaf_user_in_fifo #(.PAYLOAD_BITS(W), .DEPTH(DEPTH)) dut (
      .clk_user      (clk_user),
      .reset_n       (reset_n),
      .din_interface (din_interface),
      .vld_interface (vld_interface),
      .ack_user      (ack_user),
      .dout_user     (dout_user),
      .empty_n_user  (empty_n_user),
      .read_user     (read_user),
      .level         (level)
`ifdef LEAF_USER_FIFO_STATS_EN
      ,
      .max_level     (max_level),
      .err_underflow (err_underflow)
`endif
   );

   // Reference: contents as a queue, ack as "not full after the last edge".
   logic [W-1:0] q[$];
   bit           m_ack = 0;
   int           m_max = 0;
   bit           m_err = 0;

   always @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_ack = 0;
         m_max = 0;
         m_err = 0;
      end else begin
         bit do_wr, do_rd;
         do_wr = vld_interface && m_ack;
         do_rd = read_user && (q.size() != 0);
         if (read_user && q.size() == 0) m_err = 1;
         if (do_rd) void'(q.pop_front());
         if (do_wr) q.push_back(din_interface);
         m_ack = (q.size() != DEPTH);
         if (q.size() > m_max) m_max = q.size();
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_user) begin
      chk("level", 64'(level), 64'(q.size()));
      chk("empty_n", 64'(empty_n_user), 64'(q.size() != 0));
      chk("ack", 64'(ack_user), 64'(m_ack));
      if (q.size() != 0) chk("dout", 64'(dout_user), 64'(q[0]));
`ifdef LEAF_USER_FIFO_STATS_EN
      chk("max_level", 64'(max_level), 64'(m_max));
      chk("err_underflow", 64'(err_underflow), 64'(m_err));
`endif
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_user);
         #2;
      end
   endtask

   initial begin
      // Reset held with vld high: nothing accepted, all flags low.
      reset_n = 1'b0; vld_interface = 1'b1; din_interface = 32'h11;
      step(3);
      chk("rst_ack", 64'(ack_user), 64'd0);
      chk("rst_empty_n", 64'(empty_n_user), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      vld_interface = 1'b0;
      reset_n = 1'b1;
      step();
      chk("ack_after_release", 64'(ack_user), 64'd1);

      // Single word through the FWFT head.
      din_interface = 32'hDEADBEEF; vld_interface = 1'b1;
      step();
      vld_interface = 1'b0;
      chk("single_dout", 64'(dout_user), 64'hDEADBEEF);
      chk("single_empty_n", 64'(empty_n_user), 64'd1);
      chk("single_level", 64'(level), 64'd1);
      read_user = 1'b1;
      step();
      read_user = 1'b0;
      chk("single_drained_level", 64'(level), 64'd0);
      chk("single_drained_empty_n", 64'(empty_n_user), 64'd0);

      // Fill to DEPTH, then a 17th word must wait for a read.
      for (int i = 0; i < DEPTH; i++) begin
         din_interface = 32'(i); vld_interface = 1'b1;
         step();
      end
      din_interface = 32'h99;
      step(3);
      chk("full_level", 64'(level), 64'd16);
      chk("full_ack", 64'(ack_user), 64'd0);
      chk("full_head", 64'(dout_user), 64'd0);
      read_user = 1'b1;
      step();
      read_user = 1'b0;
      chk("after_read_level", 64'(level), 64'd15);
      chk("after_read_ack", 64'(ack_user), 64'd1);
      step();
      vld_interface = 1'b0;
      chk("refill_level", 64'(level), 64'd16);
      read_user = 1'b1;
      step(DEPTH);
      read_user = 1'b0;
      chk("drained_level", 64'(level), 64'd0);

      // Concurrent read/write across pointer wrap at constant level.
      for (int i = 0; i < 3; i++) begin
         din_interface = 32'(100 + i); vld_interface = 1'b1;
         step();
      end
      read_user = 1'b1;
      for (int i = 0; i < 40; i++) begin
         din_interface = 32'(200 + i);
         step();
      end
      vld_interface = 1'b0;
      chk("wrap_level", 64'(level), 64'd3);
      chk("wrap_head", 64'(dout_user), 64'd237);
      step(3);
      read_user = 1'b0;
      chk("wrap_drained", 64'(level), 64'd0);

      // Read while empty is ignored.
      read_user = 1'b1;
      step();
      read_user = 1'b0;
      chk("underflow_level", 64'(level), 64'd0);
      chk("underflow_empty_n", 64'(empty_n_user), 64'd0);
`ifdef LEAF_USER_FIFO_STATS_EN
      chk("underflow_err", 64'(err_underflow), 64'd1);
      step(2);
      chk("underflow_sticky", 64'(err_underflow), 64'd1);
      chk("max_hwm", 64'(max_level), 64'd16);
`endif
      // Empty with simultaneous write: write wins, level becomes 1.
      din_interface = 32'hABCD; vld_interface = 1'b1; read_user = 1'b1;
      step();
      vld_interface = 1'b0; read_user = 1'b0;
      chk("empty_wr_rd_level", 64'(level), 64'd1);
      chk("empty_wr_rd_dout", 64'(dout_user), 64'hABCD);

      // Mid-operation reset at level 9.
      for (int i = 0; i < 8; i++) begin
         din_interface = 32'(300 + i); vld_interface = 1'b1;
         step();
      end
      vld_interface = 1'b0;
      chk("pre_reset_level", 64'(level), 64'd9);
      reset_n = 1'b0;
      #1;
      chk("midrst_level", 64'(level), 64'd0);
      chk("midrst_empty_n", 64'(empty_n_user), 64'd0);
      chk("midrst_ack", 64'(ack_user), 64'd0);
`ifdef LEAF_USER_FIFO_STATS_EN
      chk("midrst_max", 64'(max_level), 64'd0);
      chk("midrst_err", 64'(err_underflow), 64'd0);
`endif
      step(2);
      reset_n = 1'b1;
      step(2);
      chk("post_reset_ack", 64'(ack_user), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_leaf_user_in_fifo

`default_nettype wire
